// File: rtl/mem_copy_master_pkg.sv
// Shared definitions for the picorv32-side copy/fill bus master:
// FSM states, write-strobe encodings, mode encodings and address helpers.
package mem_copy_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'h0;
    localparam logic [3:0]  WSTRB_WORD = 4'hF;

    localparam logic        MODE_COPY  = 1'b0;
    localparam logic        MODE_FILL  = 1'b1;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/mem_copy_timeout.sv
// Per-transaction wait counter: counts cycles a request waits for mem_ready
// and flags the cycle in which the TIMEOUT-th wait is reached (never when TIMEOUT=0).
module mem_copy_timeout #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // r_count holds the waits already seen, so this cycle is wait number LAST+1.
    assign o_expired = (TIMEOUT > 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_copy_master.sv
// Bus initiator on the picorv32 native memory interface: word-wise copy
// (read then write per word) or word fill of a region, with optional timeout.
module mem_copy_master
    import mem_copy_master_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 i_start,
    input  logic                 i_mode,
    input  logic [31:0]          i_src_addr,
    input  logic [31:0]          i_dst_addr,
    input  logic [LEN_WIDTH-1:0] i_len_words,
    input  logic [31:0]          i_fill_value,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [LEN_WIDTH-1:0] o_words_done,
    output logic                 o_mem_valid,
    output logic                 o_mem_instr,
    input  logic                 i_mem_ready,
    output logic [31:0]          o_mem_addr,
    output logic [31:0]          o_mem_wdata,
    output logic [3:0]           o_mem_wstrb,
    input  logic [31:0]          i_mem_rdata,
    output state_t               o_dbg_state
);

    // Handshake: a transaction completes on a rising edge where mem_valid && mem_ready.
    // While mem_valid waits for mem_ready, addr/wdata/wstrb hold; mem_valid only
    // drops without a handshake on timeout abort or reset.

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [LEN_WIDTH-1:0] r_len;
    logic                 r_mode;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [LEN_WIDTH-1:0] r_words_done;
    logic                 r_mem_valid;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_wstrb;

    logic                 w_handshake;
    logic                 w_wait;
    logic                 w_tmo_clear;
    logic                 w_expired;
    logic [LEN_WIDTH-1:0] w_words_next;

    assign w_handshake  = r_mem_valid && i_mem_ready;
    assign w_wait       = r_mem_valid && !i_mem_ready;
    assign w_tmo_clear  = !r_mem_valid || w_handshake;
    assign w_words_next = r_words_done + LEN_WIDTH'(1);

    mem_copy_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_len        <= '0;
            r_mode       <= MODE_COPY;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words_done <= '0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= WSTRB_READ;
        end else begin
            r_done <= 1'b0;
            if (w_expired) begin
                r_state     <= ST_DONE;
                r_busy      <= 1'b0;
                r_done      <= 1'b1;
                r_error     <= 1'b1;
                r_mem_valid <= 1'b0;
                r_mem_wstrb <= WSTRB_READ;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_start) begin
                            r_src        <= word_align(i_src_addr);
                            r_dst        <= word_align(i_dst_addr);
                            r_len        <= i_len_words;
                            r_mode       <= i_mode;
                            r_error      <= 1'b0;
                            r_words_done <= '0;
                            // wdata doubles as the fill-value latch and the copy data register.
                            r_mem_wdata  <= i_fill_value;
                            if (i_len_words == '0) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end else if (i_mode == MODE_COPY) begin
                                r_state     <= ST_READ;
                                r_busy      <= 1'b1;
                                r_mem_valid <= 1'b1;
                                r_mem_addr  <= word_align(i_src_addr);
                                r_mem_wstrb <= WSTRB_READ;
                            end else begin
                                r_state     <= ST_WRITE;
                                r_busy      <= 1'b1;
                                r_mem_valid <= 1'b1;
                                r_mem_addr  <= word_align(i_dst_addr);
                                r_mem_wstrb <= WSTRB_WORD;
                            end
                        end
                    end
                    ST_READ: begin
                        if (w_handshake) begin
                            r_src       <= r_src + WORD_BYTES;
                            r_mem_wdata <= i_mem_rdata;
                            r_mem_addr  <= r_dst;
                            r_mem_wstrb <= WSTRB_WORD;
                            r_state     <= ST_WRITE;
                        end
                    end
                    ST_WRITE: begin
                        if (w_handshake) begin
                            r_dst        <= r_dst + WORD_BYTES;
                            r_words_done <= w_words_next;
                            if (w_words_next == r_len) begin
                                r_state     <= ST_DONE;
                                r_busy      <= 1'b0;
                                r_done      <= 1'b1;
                                r_mem_valid <= 1'b0;
                                r_mem_wstrb <= WSTRB_READ;
                            end else if (r_mode == MODE_COPY) begin
                                r_state     <= ST_READ;
                                r_mem_addr  <= r_src;
                                r_mem_wstrb <= WSTRB_READ;
                            end else begin
                                r_mem_addr <= r_dst + WORD_BYTES;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_words_done = r_words_done;
    assign o_mem_valid  = r_mem_valid;
    assign o_mem_instr  = 1'b0;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wstrb  = r_mem_wstrb;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: memory responder with wait states / stall,
// table-driven and random commands against a word-level copy/fill model.
module tb_mem_copy_master;
    import mem_copy_master_pkg::*;

    localparam int LW = 16;
    localparam int TO = 5;

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [31:0]    src_addr = '0;
    logic [31:0]    dst_addr = '0;
    logic [LW-1:0]  len_words = '0;
    logic [31:0]    fill_value = '0;
    logic           busy;
    logic           done;
    logic           error;
    logic [LW-1:0]  words_done;
    logic           mem_valid;
    logic           mem_instr;
    logic           mem_ready = 1'b0;
    logic [31:0]    mem_addr;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_wstrb;
    logic [31:0]    mem_rdata = '0;
    state_t         dbg_state;

    always #5 clk = ~clk;

    mem_copy_master #(
        .LEN_WIDTH (LW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_start      (start),
        .i_mode       (mode),
        .i_src_addr   (src_addr),
        .i_dst_addr   (dst_addr),
        .i_len_words  (len_words),
        .i_fill_value (fill_value),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_words_done (words_done),
        .o_mem_valid  (mem_valid),
        .o_mem_instr  (mem_instr),
        .i_mem_ready  (mem_ready),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wstrb  (mem_wstrb),
        .i_mem_rdata  (mem_rdata),
        .o_dbg_state  (dbg_state)
    );

    // 4 KB responder memory (addresses alias modulo 4 KB) and its golden copy.
    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic [67:0] obs_q[$];
    logic [67:0] exp_q[$];

    int          wait_states = 0;
    logic        stall_en = 1'b0;
    logic [31:0] stall_addr = '0;
    int          viol = 0;
    int          total = 0;
    int          bad = 0;

    bit          rs_hs;
    int          rs_wcnt = 0;
    bit          rs_pend = 1'b0;
    logic [67:0] rs_prev = '0;

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    // Responder: logs handshakes, checks request stability, then sets ready for the next cycle.
    always @(posedge clk) begin
        rs_hs = resetn && mem_valid && mem_ready;
        if (resetn && mem_valid && rs_pend && ({mem_wstrb, mem_addr, mem_wdata} != rs_prev))
            viol++;
        rs_pend = resetn && mem_valid && !mem_ready;
        rs_prev = {mem_wstrb, mem_addr, mem_wdata};
        if (rs_hs) begin
            if (mem_wstrb == WSTRB_WORD) begin
                mem[widx(mem_addr)] = mem_wdata;
                obs_q.push_back({mem_wstrb, mem_addr, mem_wdata});
            end else begin
                obs_q.push_back({mem_wstrb, mem_addr, 32'h0});
            end
        end
        #1;
        if (rs_hs || !mem_valid) rs_wcnt = 0;
        if (mem_valid && !(stall_en && mem_wstrb == WSTRB_READ && mem_addr == stall_addr)
            && rs_wcnt >= wait_states) begin
            mem_ready = 1'b1;
            mem_rdata = mem[widx(mem_addr)];
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (mem_valid) rs_wcnt++;
        end
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word-level model: transfers proceed word by word in ascending order.
    task automatic model_cmd(input logic m, input logic [31:0] s, input logic [31:0] d,
                             input int n, input logic [31:0] f);
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] v;
        sa = word_align(s);
        da = word_align(d);
        for (int i = 0; i < n; i++) begin
            if (m == MODE_COPY) begin
                v = ref_mem[widx(sa)];
                exp_q.push_back({WSTRB_READ, sa, 32'h0});
                sa = sa + 32'd4;
            end else begin
                v = f;
            end
            ref_mem[widx(da)] = v;
            exp_q.push_back({WSTRB_WORD, da, v});
            da = da + 32'd4;
        end
    endtask

    task automatic launch(input logic m, input logic [31:0] s, input logic [31:0] d,
                          input int n, input logic [31:0] f);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; len_words = LW'(n); fill_value = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge of cycle c0 after acceptance; returns at the done cycle.
    task automatic wait_done(input int c0, input int budget, output int done_cyc, output int busy_cyc,
                             output logic [LW-1:0] wd, output logic err, output logic vld);
        done_cyc = -1; busy_cyc = 0; wd = '0; err = 1'b0; vld = 1'b0;
        for (int c = c0; c < c0 + budget; c++) begin
            if (busy) busy_cyc++;
            if (done) begin
                done_cyc = c; wd = words_done; err = error; vld = mem_valid;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic compare_log(input string tag);
        check({tag, "_txn_count"}, 72'(obs_q.size()), 72'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_txn"}, 72'(obs_q[i]), 72'(exp_q[i]));
    endtask

    task automatic compare_mem(input string tag);
        int m;
        m = 0;
        for (int i = 0; i < 1024; i++)
            if (mem[i] !== ref_mem[i]) m++;
        check({tag, "_mem_words_differing"}, 72'(m), 72'(0));
    endtask

    typedef struct {
        logic        mode;
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        logic [31:0] fill;
        int          waits;
        int          exp_busy;
        int          exp_done;
    } vec_t;

    task automatic run_cmd(input string tag, input vec_t v);
        int dc, bc;
        logic [LW-1:0] wd;
        logic er, vl;
        obs_q.delete(); exp_q.delete(); viol = 0;
        wait_states = v.waits;
        model_cmd(v.mode, v.src, v.dst, v.len, v.fill);
        launch(v.mode, v.src, v.dst, v.len, v.fill);
        wait_done(1, 300, dc, bc, wd, er, vl);
        check({tag, "_done_cycle"}, 72'(dc), 72'(v.exp_done));
        check({tag, "_busy_cycles"}, 72'(bc), 72'(v.exp_busy));
        check({tag, "_words_done"}, 72'(wd), 72'(v.len));
        check({tag, "_error"}, 72'(er), 72'(0));
        check({tag, "_valid_at_done"}, 72'(vl), 72'(0));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 72'(done), 72'(0));
        check({tag, "_busy_after"}, 72'(busy), 72'(0));
        compare_log(tag);
        compare_mem(tag);
        check({tag, "_stable_while_waiting"}, 72'(viol), 72'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        vec_t rv;
        logic [31:0] v;
        int dc, bc;
        logic [LW-1:0] wd;
        logic er, vl;
        int dn;

        vecs[0] = '{MODE_COPY, 32'h100,      32'h200, 4, 32'h0,        0, 8,  9};
        vecs[1] = '{MODE_FILL, 32'h0,        32'h300, 3, 32'hDEADBEEF, 2, 9,  10};
        vecs[2] = '{MODE_COPY, 32'h800,      32'h900, 0, 32'h0,        0, 0,  1};
        vecs[3] = '{MODE_COPY, 32'h600,      32'h700, 5, 32'h0,        1, 20, 21};
        vecs[4] = '{MODE_FILL, 32'h0,        32'h0FC, 1, 32'h12345678, 0, 1,  2};
        vecs[5] = '{MODE_COPY, 32'hFFFFFFFC, 32'h500, 2, 32'h0,        0, 4,  5};
        vecs[6] = '{MODE_FILL, 32'h3,        32'h403, 2, 32'hA5A5F00F, 1, 4,  5};

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 4; i++) begin
            mem[16'h40 + i] = 32'(i + 1);
            ref_mem[16'h40 + i] = 32'(i + 1);
        end

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 72'(busy), 72'(0));
        check("rst_done", 72'(done), 72'(0));
        check("rst_error", 72'(error), 72'(0));
        check("rst_words_done", 72'(words_done), 72'(0));
        check("rst_valid", 72'(mem_valid), 72'(0));
        check("rst_addr", 72'(mem_addr), 72'(0));
        check("rst_wdata", 72'(mem_wdata), 72'(0));
        check("rst_wstrb", 72'(mem_wstrb), 72'(0));
        check("rst_instr", 72'(mem_instr), 72'(0));
        check("rst_state", 72'(dbg_state), 72'(ST_IDLE));
        resetn = 1'b1;

        for (int i = 0; i < 7; i++)
            run_cmd($sformatf("vec%0d", i), vecs[i]);
        for (int i = 0; i < 4; i++)
            check("plan_copy_dst_word", 72'(mem[16'h80 + i]), 72'(i + 1));

        // Timeout: second read of a len=3 copy never gets ready.
        obs_q.delete(); exp_q.delete(); viol = 0;
        wait_states = 0; stall_en = 1'b1; stall_addr = 32'h104;
        model_cmd(MODE_COPY, 32'h100, 32'hA00, 1, 32'h0);
        launch(MODE_COPY, 32'h100, 32'hA00, 3, 32'h0);
        wait_done(1, 100, dc, bc, wd, er, vl);
        check("tmo_done_cycle", 72'(dc), 72'(8));
        check("tmo_busy_cycles", 72'(bc), 72'(7));
        check("tmo_error", 72'(er), 72'(1));
        check("tmo_words_done", 72'(wd), 72'(1));
        check("tmo_valid_dropped", 72'(vl), 72'(0));
        compare_log("tmo");
        compare_mem("tmo");
        check("tmo_stable_while_waiting", 72'(viol), 72'(0));
        stall_en = 1'b0;
        @(negedge clk);
        check("tmo_error_sticky", 72'(error), 72'(1));
        obs_q.delete(); exp_q.delete();
        model_cmd(MODE_FILL, 32'h0, 32'hA40, 1, 32'h0BADF00D);
        launch(MODE_FILL, 32'h0, 32'hA40, 1, 32'h0BADF00D);
        check("tmo_error_cleared", 72'(error), 72'(0));
        wait_done(1, 100, dc, bc, wd, er, vl);
        check("tmo_next_done_cycle", 72'(dc), 72'(2));
        compare_log("tmo_next");

        // start pulsed while busy must be ignored.
        obs_q.delete(); exp_q.delete(); viol = 0; wait_states = 0;
        model_cmd(MODE_COPY, 32'h140, 32'hB00, 3, 32'h0);
        launch(MODE_COPY, 32'h140, 32'hB00, 3, 32'h0);
        @(negedge clk);
        mode = MODE_FILL; src_addr = 32'h400; dst_addr = 32'hC00; len_words = LW'(1);
        fill_value = 32'h11111111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, 100, dc, bc, wd, er, vl);
        check("busy_start_done_cycle", 72'(dc), 72'(7));
        check("busy_start_busy_tail", 72'(bc), 72'(4));
        check("busy_start_words_done", 72'(wd), 72'(3));
        compare_log("busy_start");
        compare_mem("busy_start");

        // Reset during the second write of a copy.
        obs_q.delete(); exp_q.delete(); wait_states = 0;
        model_cmd(MODE_COPY, 32'h180, 32'hD00, 1, 32'h0);
        exp_q.push_back({WSTRB_READ, 32'h184, 32'h0});
        launch(MODE_COPY, 32'h180, 32'hD00, 4, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_mid_pre_wstrb", 72'(mem_wstrb), 72'(WSTRB_WORD));
        check("rst_mid_pre_addr", 72'(mem_addr), 72'(32'hD04));
        resetn = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", 72'(mem_valid), 72'(0));
        check("rst_mid_busy", 72'(busy), 72'(0));
        check("rst_mid_words_done", 72'(words_done), 72'(0));
        resetn = 1'b1;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            if (done) dn++;
            @(negedge clk);
        end
        check("rst_mid_no_done", 72'(dn), 72'(0));
        compare_log("rst_mid");
        compare_mem("rst_mid");
        rv = '{MODE_COPY, 32'h180, 32'hE00, 2, 32'h0, 0, 4, 5};
        run_cmd("rst_mid_after", rv);

        // Random commands against the model.
        for (int k = 0; k < 12; k++) begin
            rv.mode     = 1'($urandom_range(0, 1));
            rv.src      = 32'(($urandom_range(0, 1023) << 2) | $urandom_range(0, 3));
            rv.dst      = 32'(($urandom_range(0, 1023) << 2) | $urandom_range(0, 3));
            rv.len      = $urandom_range(0, 6);
            rv.fill     = $urandom;
            rv.waits    = $urandom_range(0, 3);
            rv.exp_busy = ((rv.mode == MODE_FILL) ? rv.len : 2 * rv.len) * (rv.waits + 1);
            rv.exp_done = rv.exp_busy + 1;
            run_cmd($sformatf("rnd%0d", k), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
Name: mem_copy_master

Overview:
- Bus initiator for the picorv32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Connects where the CPU would, in front of the same memory/console responder used by the simulation benches.
- Two modes: word-wise copy (src to dst) and word fill of a region.
- Reports progress, completion and bus timeout.

Parameters:
- LEN_WIDTH, 16, width of the word-count input and the progress counter.
- TIMEOUT, 0, max cycles to wait for mem_ready per transaction; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  launch command; sampled only in IDLE.
- mode  in  1  0 = copy, 1 = fill.
- src_addr  in  32  copy source byte address; bits [1:0] ignored.
- dst_addr  in  32  destination byte address; bits [1:0] ignored.
- len_words  in  LEN_WIDTH  number of 32-bit words to transfer.
- fill_value  in  32  word written in fill mode.
- busy  out  1  high from the cycle after start acceptance until the done pulse.
- done  out  1  one-cycle completion pulse, also asserted on abort.
- error  out  1  sticky timeout flag; cleared on the next accepted start.
- words_done  out  LEN_WIDTH  count of completed write handshakes.
- mem_valid  out  1  request valid.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder ready.
- mem_addr  out  32  word-aligned address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF for a write, 4'h0 for a read.
- mem_rdata  in  32  read data, valid in the handshake cycle.

Behaviour:
- Reset (clk edge with resetn=0):
  - State IDLE.
  - All outputs 0: busy, done, error, words_done, mem_valid, mem_addr, mem_wdata, mem_wstrb.
  - Internal address registers and counters cleared.
  - Reset takes effect at the next edge, including mid-transfer (mem_valid drops).
- Handshake:
  - A transaction completes on a rising edge where mem_valid && mem_ready.
  - While mem_valid=1 and no handshake has occurred, mem_addr, mem_wdata and mem_wstrb hold stable.
  - mem_valid is never deasserted before its handshake, except on timeout abort or reset.
- Latched at start acceptance (start=1 in IDLE): src, dst, len, mode, fill_value. error and words_done are cleared.
- States:
  - IDLE:
    - start with len=0 -> DONE. No bus activity.
    - start with mode=0 -> READ.
    - start with mode=1 -> WRITE.
    - start outside IDLE is ignored.
  - READ:
    - mem_valid=1, mem_wstrb=0, mem_addr=src.
    - On handshake: capture mem_rdata into the data register, src += 4, go to WRITE.
  - WRITE:
    - mem_valid=1, mem_wstrb=F, mem_addr=dst, mem_wdata = data register (copy) or fill_value (fill).
    - On handshake: dst += 4, words_done += 1.
    - If words_done+1 == len -> DONE.
    - Otherwise -> READ (copy) or stay in WRITE (fill).
  - DONE:
    - done=1 for exactly one cycle, busy=0, mem_valid=0, then IDLE.
- Timing:
  - mem_valid rises on the edge that accepts start (visible in cycle k+1 when start is accepted at edge k).
  - With mem_ready=1 every cycle, each transaction takes 1 cycle.
  - Copy of N words: busy for 2N cycles, done in cycle 2N+1 after acceptance.
  - Fill of N words: busy for N cycles, done in cycle N+1.
  - Back-to-back transactions keep mem_valid continuously high.
- Addresses: arithmetic is modulo 2^32, so 0xFFFFFFFC + 4 wraps to 0. No overlap detection; copy always proceeds in ascending order.
- Timeout (TIMEOUT>0):
  - The wait counter resets on each new transaction and increments each cycle mem_valid=1 && !mem_ready.
  - When it reaches TIMEOUT: mem_valid=0, error=1, go to DONE.
  - words_done keeps the count of completed writes.
- TIMEOUT=0: wait indefinitely.

Decomposition:
- Shared package (picorv32-side bus defs):
  - state enum {IDLE, READ, WRITE, DONE}.
  - constants WSTRB_READ=4'h0 and WSTRB_WORD=4'hF.
  - mode constants MODE_COPY=0 and MODE_FILL=1.
- One natural sub-module: mem_copy_timeout (per-transaction wait counter with clear/enable/expired).
- The FSM and address/count datapath stay in the top module.

Test Plan:
- Copy, zero-wait responder: src=0x100, dst=0x200, len=4, memory[0x40..0x43] = {1,2,3,4}.
  - Bus sequence alternates R 0x100, W 0x200, ... R 0x10C, W 0x20C.
  - memory[0x80..0x83] = {1,2,3,4}; done in cycle 9; words_done=4; error=0.
- Fill with 2 wait states per transaction: dst=0x300, len=3, fill_value=0xDEADBEEF.
  - Address/wdata are stable across the waits; three writes with wstrb=F.
  - busy lasts 9 cycles; done pulses once.
- len=0 start: no mem_valid ever; done pulses the cycle after acceptance; busy never rises.
- TIMEOUT=5, responder never ready on the 2nd read of a len=3 copy:
  - mem_valid drops after 5 wait cycles; error=1; done pulse; words_done=1.
  - A subsequent start clears error.
- start pulsed during busy with different src: ignored, and the original transfer completes unchanged. Address wrap case: src=0xFFFFFFFC, len=2 -> second read at 0x00000000.
- resetn=0 for one cycle during the 2nd write of a copy: mem_valid, busy and words_done are 0 on the following cycle; no done pulse; the next start works normally.
